// File: rtl/countdown_ctrl.sv
// Control stage for a cascaded BCD countdown (mins:tens:units).
// Debounces the start/load buttons, prescales the system clock into a
// countdown tick, chains borrows into per-digit count enables and raises
// done once the counters have sat at 00:00 for a full tick period.
module countdown_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic       zero_units,
    input  logic       zero_tens,
    input  logic       zero_mins,
    output logic       load,
    output logic       tick_units,
    output logic       tick_tens,
    output logic       tick_mins,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LOADED = 3'b001,
        RUN    = 3'b010,
        PAUSE  = 3'b011,
        DONE   = 3'b100
    } state_t;

    // Bit 1 is the load button, bit 0 the start button.
    logic [1:0] btn_raw;
    logic [1:0] press_pulse;
    logic       load_press;
    logic       start_press;

    assign btn_raw     = {btn_load, btn_start};
    assign load_press  = press_pulse[1];
    assign start_press = press_pulse[0];

    // One synchronizer + debouncer per button; only a debounced rising edge
    // produces a one-cycle press pulse, releases are silent.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic          sync1;
        logic          sync2;
        logic          level;
        logic          pulse;
        logic [DW-1:0] stable_cnt;

        // Synchronize the raw button, then accept a new level only after it
        // has disagreed with the accepted level for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync1      <= 1'b0;
                sync2      <= 1'b0;
                level      <= 1'b0;
                pulse      <= 1'b0;
                stable_cnt <= '0;
            end else begin
                sync1 <= btn_raw[gi];
                sync2 <= sync1;
                pulse <= 1'b0;
                if (sync2 == level) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level      <= sync2;
                    pulse      <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end

        assign press_pulse[gi] = pulse;
    end

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          load_d;
    logic          tick_units_d;
    logic          tick_tens_d;
    logic          tick_mins_d;
    logic          all_zero;

    assign all_zero = zero_units & zero_tens & zero_mins;
    assign state    = state_q;

    // Next-state logic: load overrides everything; in RUN the prescaler's
    // terminal count either finishes (counters at 00:00) or issues a tick
    // whose borrow chain follows the zero flags sampled in that same cycle.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        load_d       = 1'b0;
        tick_units_d = 1'b0;
        tick_tens_d  = 1'b0;
        tick_mins_d  = 1'b0;
        if (load_press) begin
            load_d  = 1'b1;
            state_d = LOADED;
            presc_d = '0;
        end else begin
            case (state_q)
                LOADED: begin
                    if (start_press) begin
                        state_d = all_zero ? DONE : RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (all_zero) begin
                            state_d = DONE;
                        end else begin
                            tick_units_d = 1'b1;
                            tick_tens_d  = zero_units;
                            tick_mins_d  = zero_units & zero_tens;
                            if (start_press) state_d = PAUSE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                        if (start_press) state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_press) state_d = RUN;
                end
                default: begin
                end
            endcase
        end
    end

    // State, prescaler and every output are registered so the counters see
    // clean single-cycle enables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            load       <= 1'b0;
            tick_units <= 1'b0;
            tick_tens  <= 1'b0;
            tick_mins  <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            load       <= load_d;
            tick_units <= tick_units_d;
            tick_tens  <= tick_tens_d;
            tick_mins  <= tick_mins_d;
            running    <= (state_d == RUN);
            done       <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with behavioural BCD counters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_load = 1'b0;
    logic       zero_units;
    logic       zero_tens;
    logic       zero_mins;
    logic       load;
    logic       tick_units;
    logic       tick_tens;
    logic       tick_mins;
    logic       running;
    logic       done;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    int units_cnt = 0;
    int tens_cnt = 0;
    int mins_cnt = 0;
    int preset_mins = 0;
    int preset_tens = 0;
    int preset_units = 0;

    always #5 clock = ~clock;

    countdown_ctrl #(
        .CLK_HZ(10),
        .TICK_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .btn_start(btn_start),
        .btn_load(btn_load),
        .zero_units(zero_units),
        .zero_tens(zero_tens),
        .zero_mins(zero_mins),
        .load(load),
        .tick_units(tick_units),
        .tick_tens(tick_tens),
        .tick_mins(tick_mins),
        .running(running),
        .done(done),
        .state(state)
    );

    // Behavioural down-counters: units 9->0, tens 5->0, mins 9->0.
    always @(posedge clock) begin
        if (load) begin
            mins_cnt  <= preset_mins;
            tens_cnt  <= preset_tens;
            units_cnt <= preset_units;
        end else begin
            if (tick_units) units_cnt <= (units_cnt == 0) ? 9 : units_cnt - 1;
            if (tick_tens)  tens_cnt  <= (tens_cnt == 0) ? 5 : tens_cnt - 1;
            if (tick_mins)  mins_cnt  <= (mins_cnt == 0) ? 9 : mins_cnt - 1;
        end
    end

    assign zero_units = (units_cnt == 0);
    assign zero_tens  = (tens_cnt == 0);
    assign zero_mins  = (mins_cnt == 0);

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic ld, input logic st);
        btn_load  = ld;
        btn_start = st;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Counts tick pulses over n cycles.
    task automatic countTicks(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            cycles(1);
            if (tick_units || tick_tens || tick_mins) ticks++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [2:0] exp_ticks;

        // Reset state
        preset_mins = 1; preset_tens = 0; preset_units = 5;
        cycles(3);
        checkOutput("reset_state", state, 3'b000);
        checkOutput("reset_outputs", {load, tick_mins, tick_tens, tick_units, running, done}, 6'b0);
        reset_n = 1'b1;
        cycles(2);

        // 1: load button held; pulse after 2 sync + 4 stable + 1 cycles
        applyStimulus(1'b1, 1'b0);
        cycles(6);
        checkOutput("load_early", load, 1'b0);
        cycles(1);
        checkOutput("load_pulse", load, 1'b1);
        checkOutput("loaded_state", state, 3'b001);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (load) n++;
        end
        checkOutput("load_no_repeat", n, 0);
        applyStimulus(1'b0, 1'b0);
        cycles(8);

        // 2: run from 1:05 with borrow chaining
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("run_state", state, 3'b010);
        checkOutput("running_flag", running, 1'b1);
        applyStimulus(1'b0, 1'b0);
        cycles(9);
        checkOutput("no_tick_before_first", {tick_mins, tick_tens, tick_units}, 3'b000);
        for (int k = 0; k < 16; k++) begin
            cycles(1);
            if (k == 5)       exp_ticks = 3'b111;
            else if (k == 15) exp_ticks = 3'b011;
            else              exp_ticks = 3'b001;
            checkOutput($sformatf("tick_%0d", k), {tick_mins, tick_tens, tick_units}, exp_ticks);
            cycles(9);
            checkOutput($sformatf("gap_%0d", k), {tick_mins, tick_tens, tick_units}, 3'b000);
        end
        checkOutput("display_0_49", mins_cnt * 100 + tens_cnt * 10 + units_cnt, 49);

        // 3: reload 0:02 mid-run, count down to DONE
        preset_mins = 0; preset_tens = 0; preset_units = 2;
        applyStimulus(1'b1, 1'b0);
        cycles(7);
        checkOutput("reload_pulse", load, 1'b1);
        checkOutput("reload_state", state, 3'b001);
        applyStimulus(1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("run2_state", state, 3'b010);
        applyStimulus(1'b0, 1'b0);
        cycles(10);
        checkOutput("tick_0_01", {tick_mins, tick_tens, tick_units}, 3'b001);
        cycles(10);
        checkOutput("tick_0_00", {tick_mins, tick_tens, tick_units}, 3'b001);
        cycles(9);
        checkOutput("hold_00_00", state, 3'b010);
        cycles(1);
        checkOutput("done_state", state, 3'b100);
        checkOutput("done_flags", {done, running}, 2'b10);
        checkOutput("done_no_tick", {tick_mins, tick_tens, tick_units}, 3'b000);
        countTicks(20, n);
        checkOutput("done_quiet", n, 0);
        checkOutput("done_held", done, 1'b1);

        // 4: pause at prescaler 6, resume, first tick 3 cycles later
        preset_mins = 5; preset_tens = 3; preset_units = 0;
        applyStimulus(1'b1, 1'b0);
        cycles(7);
        checkOutput("load_530", state, 3'b001);
        applyStimulus(1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("run3_state", state, 3'b010);
        applyStimulus(1'b0, 1'b0);
        cycles(10);
        checkOutput("tick_5_30", {tick_mins, tick_tens, tick_units}, 3'b011);
        applyStimulus(1'b0, 1'b1);
        cycles(6);
        checkOutput("pre_pause", state, 3'b010);
        cycles(1);
        checkOutput("pause_state", state, 3'b011);
        checkOutput("pause_running", running, 1'b0);
        applyStimulus(1'b0, 1'b0);
        countTicks(15, n);
        checkOutput("pause_quiet", n, 0);
        checkOutput("pause_holds", state, 3'b011);
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("resume_state", state, 3'b010);
        applyStimulus(1'b0, 1'b0);
        cycles(2);
        checkOutput("resume_no_tick", {tick_mins, tick_tens, tick_units}, 3'b000);
        cycles(1);
        checkOutput("resume_tick", {tick_mins, tick_tens, tick_units}, 3'b001);

        // 5: short glitches ignored; simultaneous presses -> load only
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b1);
            cycles(2);
            applyStimulus(1'b0, 1'b0);
            cycles(3);
            checkOutput($sformatf("glitch_%0d", g), state, 3'b010);
        end
        cycles(4);
        checkOutput("glitch_settled", state, 3'b010);
        preset_mins = 0; preset_tens = 0; preset_units = 0;
        applyStimulus(1'b1, 1'b1);
        cycles(7);
        checkOutput("both_load", load, 1'b1);
        checkOutput("both_state", state, 3'b001);
        cycles(5);
        checkOutput("both_start_dropped", state, 3'b001);
        applyStimulus(1'b0, 1'b0);
        cycles(8);

        // 6: start at 0:00 goes straight to DONE
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("zero_done", state, 3'b100);
        checkOutput("zero_done_flag", done, 1'b1);
        applyStimulus(1'b0, 1'b0);
        countTicks(15, n);
        checkOutput("zero_no_ticks", n, 0);

        // 6: asynchronous reset in the middle of RUN
        preset_mins = 2; preset_tens = 0; preset_units = 0;
        applyStimulus(1'b1, 1'b0);
        cycles(7);
        checkOutput("load_200", state, 3'b001);
        applyStimulus(1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 1'b1);
        cycles(7);
        checkOutput("run4_state", state, 3'b010);
        applyStimulus(1'b0, 1'b0);
        cycles(10);
        checkOutput("tick_2_00", {tick_mins, tick_tens, tick_units}, 3'b111);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_state", state, 3'b000);
        checkOutput("async_reset_outputs", {load, tick_mins, tick_tens, tick_units, running, done}, 6'b0);
        cycles(3);
        checkOutput("reset_hold", state, 3'b000);
        reset_n = 1'b1;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
